icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, read-only instruction cache between the fetch stage and instruction memory. Serves one fetch address per cycle from a register-based line store and returns the addressed word and its successor on a hit. On a miss it stalls fetch, issues one 256-bit block read to instruction memory and installs the line. `flush_2IC` bulk-invalidates the cache for syscall handling.

## Interface
Parameters:
- `NUM_LINES`, default 32: number of lines; power of two, minimum 2.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `Instr_address_2IC`  in  32  fetch byte address from IF; bits [1:0] are ignored.
- `Instr1_fIC`  out  32  word at the fetch address.
- `Instr2_fIC`  out  32  word at fetch address + 4.
- `Instr2_valid_fIC`  out  1  `Instr2_fIC` is usable; low when offset = 7.
- `IC_STALL`  out  1  IF must hold `Instr_address_2IC` and discard outputs.
- `Instr_address_2IM`  out  32  line-aligned miss address `{addr[31:5], 5'b0}`.
- `iBlkRead`  out  1  block read request to IM.
- `block_read_fIM`  in  256  fill data; word i at bits [32i+31:32i].
- `block_read_fIM_valid`  in  1  fill data valid this cycle.
- `flush_2IC`  in  1  invalidate all lines.
- `hit_count`  out  32  saturating hit counter.
- `miss_count`  out  32  saturating miss counter.

## Operation
- Address split: offset [4:2], index [4+log2(NUM_LINES):5], tag = remaining upper bits. With 32 lines: index [9:5], tag [31:10].
- Per line state: valid bit, tag, 256-bit data.
- FSM states:
  - IDLE
    - Hit (`valid[index]` and tag match): drive `Instr1_fIC` = word[offset].
    - Drive `Instr2_fIC` = word[offset+1] when offset < 7, else 0 with `Instr2_valid_fIC` = 0.
    - Hit: `IC_STALL` = 0; increment `hit_count`.
    - Miss: `IC_STALL` = 1 in the same cycle. Latch the line-aligned address into `Instr_address_2IM`. Increment `miss_count`. Go to FETCH.
  - FETCH
    - `iBlkRead` = 1 and `IC_STALL` = 1 throughout.
    - On the cycle `block_read_fIM_valid` = 1: write data and tag, set valid, deassert `iBlkRead` next cycle, go to IDLE.
    - `iBlkRead` stays high until valid arrives; there is no timeout.
- While `IC_STALL` = 1: `Instr1_fIC` = 0, `Instr2_fIC` = 0, `Instr2_valid_fIC` = 0.
- The fetch address may change during FETCH (for example, a redirect). The fill still completes for the latched address. The new address is looked up in IDLE.
- Flush:
  - In IDLE: all valid bits clear at the next edge. The lookup in the flush cycle still uses the old valid bits.
  - In FETCH, including the fill cycle: clears all valid bits; the pending fill is still installed valid (the fill index wins).
- Counters: saturate at 32'hFFFF_FFFF. Not cleared by flush.

## Timing
- Reset (synchronous):
  - State = IDLE; all valid bits = 0.
  - `iBlkRead` = 0, `Instr_address_2IM` = 0, counters = 0.
  - `IC_STALL` and instruction outputs forced to 0 while `RESET` is high.
  - Reset during FETCH abandons the fill; a late `block_read_fIM_valid` is ignored.
- Hit latency: 0 cycles (combinational from `Instr_address_2IC`).
- Miss penalty: a miss in cycle t gives `iBlkRead` = 1 from t+1. With valid at cycle t+1+L, the hit is served at t+2+L.
- `Instr_address_2IM` is stable whenever `iBlkRead` = 1.
- Data is invalid until after 1 reset cycle; any fetch after reset misses.

## Structure
- Package `icache_pkg`:
  - state enum {IDLE, FETCH}
  - `LINE_BITS` = 256, `WORDS_PER_LINE` = 8, `OFFSET_W` = 3
  - functions for index/tag width from `NUM_LINES`
- Sub-module `icache_line_store`:
  - valid/tag/data register arrays
  - one combinational read port (index → valid, tag, line)
  - one write port (fill)
  - a flush input clearing all valid bits
- FSM, counters and output muxing live in `icache_dm`.

## Test plan
- Cold miss: reset, fetch 0x0040_0000 → `IC_STALL` = 1 same cycle; `iBlkRead` = 1 with `Instr_address_2IM` = 0x0040_0000. Return a block with word i = 0x1000_0000+i after 3 cycles → next cycle `Instr1_fIC` = 0x1000_0000, `Instr2_fIC` = 0x1000_0001, `miss_count` = 1.
- Hits within line: fetch 0x0040_0004 then 0x0040_001C → 0x1000_0001/0x1000_0002, then 0x1000_0007 with `Instr2_valid_fIC` = 0; `hit_count` = 2; no `iBlkRead`.
- Conflict: with 32 lines, fetch 0x0040_0400 (same index 0, different tag) → miss and refill. Refetching 0x0040_0000 misses again.
- Flush: after the line is filled, pulse `flush_2IC` in IDLE → same-cycle lookup hits, next fetch of 0x0040_0000 misses. Flush on the fill cycle → filled line hits afterwards.
- Redirect during FETCH: change the address to 0x0040_0100 mid-fill → 0x0040_0000 line installed, then second miss for 0x0040_0100.
- Reset mid-FETCH: assert `RESET` while `iBlkRead` = 1, then drive `block_read_fIM_valid` → `iBlkRead` = 0; no line becomes valid; counters = 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, geometry constants and address-split helpers for the
// direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic {
      IDLE,
      FETCH
   } cacheState_t;

   localparam int LINE_BITS      = 256;
   localparam int WORDS_PER_LINE = 8;
   localparam int OFFSET_W       = 3;

   function automatic int indexWidth(input int numLines);
      return $clog2(numLines);
   endfunction

   // Two byte-offset bits plus the word offset sit below the index.
   function automatic int tagWidth(input int numLines);
      return 32 - OFFSET_W - 2 - $clog2(numLines);
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Register-based line store: valid/tag/data arrays with one combinational
// read port, one fill write port and a bulk valid clear.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int  NUM_LINES = 32,
   localparam int IDX_W     = indexWidth(NUM_LINES),
   localparam int TAG_W     = tagWidth(NUM_LINES)
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 flush,
   input  logic [IDX_W-1:0]     rdIdx,
   output logic                 rdValid,
   output logic [TAG_W-1:0]     rdTag,
   output logic [LINE_BITS-1:0] rdLine,
   input  logic                 wrEn,
   input  logic [IDX_W-1:0]     wrIdx,
   input  logic [TAG_W-1:0]     wrTag,
   input  logic [LINE_BITS-1:0] wrLine
);

   logic [NUM_LINES-1:0] validQ;
   logic [TAG_W-1:0]     tagQ  [NUM_LINES];
   logic [LINE_BITS-1:0] dataQ [NUM_LINES];

   // A fill landing in the same cycle as a flush still installs valid.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         validQ <= '0;
      end else begin
         if (flush) begin
            validQ <= '0;
         end
         if (wrEn) begin
            validQ[wrIdx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (wrEn) begin
         tagQ[wrIdx]  <= wrTag;
         dataQ[wrIdx] <= wrLine;
      end
   end

   assign rdValid = validQ[rdIdx];
   assign rdTag   = tagQ[rdIdx];
   assign rdLine  = dataQ[rdIdx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits returning two
// consecutive words, single block-read refill on a miss, bulk flush.
module icache_dm
   import icache_pkg::*;
#(
   parameter int NUM_LINES = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [31:0]          Instr_address_2IC,
   output logic [31:0]          Instr1_fIC,
   output logic [31:0]          Instr2_fIC,
   output logic                 Instr2_valid_fIC,
   output logic                 IC_STALL,
   output logic [31:0]          Instr_address_2IM,
   output logic                 iBlkRead,
   input  logic [LINE_BITS-1:0] block_read_fIM,
   input  logic                 block_read_fIM_valid,
   input  logic                 flush_2IC,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
);

   localparam int IDX_W = indexWidth(NUM_LINES);
   localparam int TAG_W = tagWidth(NUM_LINES);

   cacheState_t state, stateNext;

   logic [OFFSET_W-1:0]  offset, nextOffset;
   logic [IDX_W-1:0]     lookupIdx, fillIdx;
   logic [TAG_W-1:0]     lookupTag, fillTag, rdTag;
   logic                 rdValid, hit;
   logic [LINE_BITS-1:0] rdLine;
   logic                 fillEn, hitEvt, missEvt;
   logic                 unusedByteBits;

   assign offset     = Instr_address_2IC[4:2];
   assign nextOffset = offset + OFFSET_W'(1);
   assign lookupIdx  = Instr_address_2IC[5 +: IDX_W];
   assign lookupTag  = Instr_address_2IC[31 -: TAG_W];
   // Fills always target the latched miss address, not the live fetch address.
   assign fillIdx    = Instr_address_2IM[5 +: IDX_W];
   assign fillTag    = Instr_address_2IM[31 -: TAG_W];
   assign unusedByteBits = ^Instr_address_2IC[1:0];

   icache_line_store #(.NUM_LINES(NUM_LINES)) lineStore (
      .CLK     (CLK),
      .RESET   (RESET),
      .flush   (flush_2IC),
      .rdIdx   (lookupIdx),
      .rdValid (rdValid),
      .rdTag   (rdTag),
      .rdLine  (rdLine),
      .wrEn    (fillEn),
      .wrIdx   (fillIdx),
      .wrTag   (fillTag),
      .wrLine  (block_read_fIM)
   );

   assign hit = rdValid && (rdTag == lookupTag);

   always_comb begin
      stateNext        = state;
      iBlkRead         = 1'b0;
      IC_STALL         = 1'b0;
      Instr1_fIC       = '0;
      Instr2_fIC       = '0;
      Instr2_valid_fIC = 1'b0;
      hitEvt           = 1'b0;
      missEvt          = 1'b0;
      fillEn           = 1'b0;
      if (!RESET) begin
         case (state)
            IDLE: begin
               if (hit) begin
                  hitEvt     = 1'b1;
                  Instr1_fIC = rdLine[{offset, 5'b0} +: 32];
                  if (offset != OFFSET_W'(WORDS_PER_LINE - 1)) begin
                     Instr2_fIC       = rdLine[{nextOffset, 5'b0} +: 32];
                     Instr2_valid_fIC = 1'b1;
                  end
               end else begin
                  IC_STALL  = 1'b1;
                  missEvt   = 1'b1;
                  stateNext = FETCH;
               end
            end
            FETCH: begin
               iBlkRead = 1'b1;
               IC_STALL = 1'b1;
               if (block_read_fIM_valid) begin
                  fillEn    = 1'b1;
                  stateNext = IDLE;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state             <= IDLE;
         Instr_address_2IM <= '0;
         hit_count         <= '0;
         miss_count        <= '0;
      end else begin
         state <= stateNext;
         if (missEvt) begin
            Instr_address_2IM <= {Instr_address_2IC[31:5], 5'b0};
         end
         if (hitEvt && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (missEvt && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, in-line hits, conflict refill,
// flush in IDLE and on the fill cycle, redirect during fetch, reset mid-fetch.
module tb_icache_dm;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  Instr_address_2IC;
   logic [31:0]  Instr1_fIC;
   logic [31:0]  Instr2_fIC;
   logic         Instr2_valid_fIC;
   logic         IC_STALL;
   logic [31:0]  Instr_address_2IM;
   logic         iBlkRead;
   logic [255:0] block_read_fIM;
   logic         block_read_fIM_valid;
   logic         flush_2IC;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   icache_dm #(.NUM_LINES(32)) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .Instr_address_2IC    (Instr_address_2IC),
      .Instr1_fIC           (Instr1_fIC),
      .Instr2_fIC           (Instr2_fIC),
      .Instr2_valid_fIC     (Instr2_valid_fIC),
      .IC_STALL             (IC_STALL),
      .Instr_address_2IM    (Instr_address_2IM),
      .iBlkRead             (iBlkRead),
      .block_read_fIM       (block_read_fIM),
      .block_read_fIM_valid (block_read_fIM_valid),
      .flush_2IC            (flush_2IC),
      .hit_count            (hit_count),
      .miss_count           (miss_count)
   );

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [255:0] makeBlock(input logic [31:0] base);
      logic [255:0] blk;
      for (int i = 0; i < 8; i++) begin
         blk[32*i +: 32] = base + 32'(i);
      end
      return blk;
   endfunction

   task automatic checkStalled(input string tag);
      checkVal({tag, "_stall"}, 32'(IC_STALL), 32'd1);
      checkVal({tag, "_i1"}, Instr1_fIC, 32'd0);
      checkVal({tag, "_i2"}, Instr2_fIC, 32'd0);
      checkVal({tag, "_i2v"}, 32'(Instr2_valid_fIC), 32'd0);
   endtask

   task automatic checkHit(input string tag, input logic [31:0] exp1, input logic [31:0] exp2,
                           input logic expV2);
      checkVal({tag, "_stall"}, 32'(IC_STALL), 32'd0);
      checkVal({tag, "_i1"}, Instr1_fIC, exp1);
      checkVal({tag, "_i2"}, Instr2_fIC, exp2);
      checkVal({tag, "_i2v"}, 32'(Instr2_valid_fIC), 32'(expV2));
   endtask

   // Presents fill data for exactly one cycle while the cache is in FETCH.
   task automatic fillLine(input logic [31:0] base, input logic withFlush);
      block_read_fIM       = makeBlock(base);
      block_read_fIM_valid = 1'b1;
      flush_2IC            = withFlush;
      settle();
      checkVal("fill_cycle_stall", 32'(IC_STALL), 32'd1);
      step();
      block_read_fIM_valid = 1'b0;
      flush_2IC            = 1'b0;
      settle();
      checkVal("after_fill_blkread", 32'(iBlkRead), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET                = 1'b1;
      Instr_address_2IC    = 32'h0040_0000;
      block_read_fIM       = '0;
      block_read_fIM_valid = 1'b0;
      flush_2IC            = 1'b0;
      step();
      step();
      settle();
      checkVal("rst_stall", 32'(IC_STALL), 32'd0);
      checkVal("rst_blkread", 32'(iBlkRead), 32'd0);
      checkVal("rst_addr_im", Instr_address_2IM, 32'd0);
      checkVal("rst_hits", hit_count, 32'd0);
      checkVal("rst_misses", miss_count, 32'd0);
      checkVal("rst_i1", Instr1_fIC, 32'd0);

      // Cold miss on 0x0040_0000; data returns on the third FETCH cycle.
      step();
      RESET = 1'b0;
      settle();
      checkStalled("cold_miss");
      checkVal("cold_no_blkread_yet", 32'(iBlkRead), 32'd0);
      step();
      settle();
      checkVal("cold_blkread", 32'(iBlkRead), 32'd1);
      checkVal("cold_addr_im", Instr_address_2IM, 32'h0040_0000);
      checkVal("cold_misses", miss_count, 32'd1);
      checkStalled("cold_fetch");
      step();
      settle();
      checkVal("cold_blkread_hold", 32'(iBlkRead), 32'd1);
      step();
      fillLine(32'h1000_0000, 1'b0);
      checkHit("cold_served", 32'h1000_0000, 32'h1000_0001, 1'b1);
      checkVal("cold_misses_after", miss_count, 32'd1);
      checkVal("cold_hits_after", hit_count, 32'd0);

      // Hits within the line, including the last word of the line.
      step();
      Instr_address_2IC = 32'h0040_0004;
      settle();
      checkHit("hit_w1", 32'h1000_0001, 32'h1000_0002, 1'b1);
      checkVal("hit_w1_count", hit_count, 32'd1);
      step();
      Instr_address_2IC = 32'h0040_001C;
      settle();
      checkHit("hit_w7", 32'h1000_0007, 32'h0000_0000, 1'b0);
      checkVal("hit_w7_count", hit_count, 32'd2);
      checkVal("hit_w7_blkread", 32'(iBlkRead), 32'd0);

      // Conflict: same index 0, different tag.
      step();
      Instr_address_2IC = 32'h0040_0400;
      settle();
      checkStalled("conflict_miss");
      checkVal("conflict_hits", hit_count, 32'd3);
      step();
      settle();
      checkVal("conflict_addr_im", Instr_address_2IM, 32'h0040_0400);
      checkVal("conflict_misses", miss_count, 32'd2);
      fillLine(32'h2000_0000, 1'b0);
      checkHit("conflict_served", 32'h2000_0000, 32'h2000_0001, 1'b1);
      Instr_address_2IC = 32'h0040_0000;
      settle();
      checkStalled("evicted_miss");

      // Refill the evicted line with a flush on the fill cycle.
      step();
      settle();
      checkVal("refill_addr_im", Instr_address_2IM, 32'h0040_0000);
      checkVal("refill_misses", miss_count, 32'd3);
      fillLine(32'h1000_0000, 1'b1);
      checkHit("flush_on_fill_hit", 32'h1000_0000, 32'h1000_0001, 1'b1);

      // Flush in IDLE: same-cycle lookup still hits, the next one misses.
      flush_2IC = 1'b1;
      settle();
      checkHit("flush_idle_same", 32'h1000_0000, 32'h1000_0001, 1'b1);
      step();
      flush_2IC = 1'b0;
      settle();
      checkStalled("flush_idle_next");
      checkVal("flush_hits", hit_count, 32'd4);
      checkVal("flush_misses_kept", miss_count, 32'd3);

      // Redirect during FETCH: the latched line still fills, then a new miss.
      step();
      Instr_address_2IC = 32'h0040_0100;
      settle();
      checkVal("redir_addr_im", Instr_address_2IM, 32'h0040_0000);
      checkVal("redir_blkread", 32'(iBlkRead), 32'd1);
      checkVal("redir_misses", miss_count, 32'd4);
      fillLine(32'h3000_0000, 1'b0);
      checkStalled("redir_new_miss");
      step();
      settle();
      checkVal("redir2_addr_im", Instr_address_2IM, 32'h0040_0100);
      checkVal("redir2_misses", miss_count, 32'd5);
      fillLine(32'h4000_0000, 1'b0);
      checkHit("redir2_served", 32'h4000_0000, 32'h4000_0001, 1'b1);
      Instr_address_2IC = 32'h0040_0008;
      settle();
      checkHit("redir_old_line", 32'h3000_0002, 32'h3000_0003, 1'b1);
      step();
      settle();
      checkVal("redir_hits", hit_count, 32'd5);

      // Reset mid-FETCH: the late fill is ignored and nothing becomes valid.
      Instr_address_2IC = 32'h0040_0200;
      settle();
      checkStalled("rstfetch_miss");
      step();
      settle();
      checkVal("rstfetch_blkread", 32'(iBlkRead), 32'd1);
      checkVal("rstfetch_misses", miss_count, 32'd6);
      RESET = 1'b1;
      settle();
      checkVal("rstfetch_blkread_rst", 32'(iBlkRead), 32'd0);
      checkVal("rstfetch_stall_rst", 32'(IC_STALL), 32'd0);
      step();
      block_read_fIM       = makeBlock(32'h5000_0000);
      block_read_fIM_valid = 1'b1;
      step();
      RESET = 1'b0;
      settle();
      checkVal("rstfetch_blkread_after", 32'(iBlkRead), 32'd0);
      checkVal("rstfetch_hits", hit_count, 32'd0);
      checkVal("rstfetch_misses_clr", miss_count, 32'd0);
      checkVal("rstfetch_addr_im", Instr_address_2IM, 32'd0);
      checkStalled("rstfetch_line_invalid");
      Instr_address_2IC = 32'h0040_0000;
      settle();
      checkStalled("rstfetch_line0_invalid");
      block_read_fIM_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
